// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and control unit for the five-stage pipeline. Drives the write
//   enables and NOP-flush strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers, plus the PC write enable and the redirect select. Covers
//   cache-wait freezes, load-use bubbles, branch/jump redirects and the
//   halt drain. Also keeps saturating stall and flush cycle counters.
//
// Ports
//   CLK, nRST                  clock, asynchronous active-low reset
//   ihit, dhit                 instruction / data access completes this cycle
//   ifid_rs, ifid_rt           source registers of the instruction in IF/ID
//   idex_MemRead, idex_rt      load in ID/EX and its destination register
//   idex_Jump                  jump in ID/EX
//   exmem_MemRead/MemWrite     memory access pending in EX/MEM
//   exmem_branch_taken         branch resolved taken in MEM
//   memwb_halt                 halt instruction has reached MEM/WB
//   pc_WEN, pc_redirect        PC update enable and target select
//   *_WEN, *_flush             pipeline register write enables / NOP inserts
//   halt                       registered halted flag
//   stall_cnt, flush_cnt       saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rt,
  input  logic             idex_Jump,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             exmem_branch_taken,
  input  logic             memwb_halt,
  output logic             pc_WEN,
  output logic             pc_redirect,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RESET, RUN, MEMWAIT, HALTED} state_t;

  state_t state;
  logic   active;
  logic   data_freeze;
  logic   freeze;
  logic   load_use;
  logic   stall_inc;
  logic   flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign active      = (state == RUN) || (state == MEMWAIT);
  assign data_freeze = (exmem_MemRead | exmem_MemWrite) & ~dhit;
  assign freeze      = data_freeze | ~ihit;
  // $zero never creates a dependency, so a load into r0 needs no bubble.
  assign load_use    = idex_MemRead && (idex_rt != 5'd0) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    pc_WEN      = 1'b0;
    pc_redirect = 1'b0;
    ifid_WEN    = 1'b0;
    idex_WEN    = 1'b0;
    exmem_WEN   = 1'b0;
    memwb_WEN   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (active) begin
      if (memwb_halt) begin
        // drain: everything frozen, FSM moves to HALTED
      end else if (freeze) begin
        // full freeze keeps any pending branch/load-use in place
        stall_inc = 1'b1;
      end else if (exmem_branch_taken) begin
        pc_WEN      = 1'b1;
        pc_redirect = 1'b1;
        ifid_WEN    = 1'b1;
        idex_WEN    = 1'b1;
        exmem_WEN   = 1'b1;
        memwb_WEN   = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (idex_Jump) begin
        pc_WEN      = 1'b1;
        pc_redirect = 1'b1;
        ifid_WEN    = 1'b1;
        idex_WEN    = 1'b1;
        exmem_WEN   = 1'b1;
        memwb_WEN   = 1'b1;
        ifid_flush  = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        // hold PC and IF/ID, push a bubble into ID/EX
        idex_WEN    = 1'b1;
        exmem_WEN   = 1'b1;
        memwb_WEN   = 1'b1;
        idex_flush  = 1'b1;
        stall_inc   = 1'b1;
      end else begin
        pc_WEN      = 1'b1;
        ifid_WEN    = 1'b1;
        idex_WEN    = 1'b1;
        exmem_WEN   = 1'b1;
        memwb_WEN   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RESET;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RESET: state <= RUN;
        RUN, MEMWAIT: begin
          if (memwb_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (data_freeze) begin
            state <= MEMWAIT;
          end else begin
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
          halt  <= 1'b1;
        end
        default: state <= RESET;
      endcase
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed vectors with hand-computed
// expectations pushed to a scoreboard queue, checked by a separate monitor
// on the falling clock edge. Counters are narrowed to 4 bits so that
// saturation is reachable in a short run.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 4;

  localparam logic [5:0] W_NONE = 6'b000000;
  localparam logic [5:0] W_ALL  = 6'b101111; // {pc_WEN,pc_redirect,ifid,idex,exmem,memwb}
  localparam logic [5:0] W_RED  = 6'b111111;
  localparam logic [5:0] W_LU   = 6'b000111;
  localparam logic [3:0] F_NONE = 4'b0000;   // {ifid,idex,exmem,memwb}
  localparam logic [3:0] F_BR   = 4'b1110;
  localparam logic [3:0] F_J    = 4'b1000;
  localparam logic [3:0] F_LU   = 4'b0100;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit;
  logic [4:0]    ifid_rs, ifid_rt, idex_rt;
  logic          idex_MemRead, idex_Jump;
  logic          exmem_MemRead, exmem_MemWrite, exmem_branch_taken, memwb_halt;
  logic          pc_WEN, pc_redirect;
  logic          ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic          halt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string         name;
    logic [5:0]    w;
    logic [3:0]    f;
    logic          h;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt), .idex_Jump(idex_Jump),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .exmem_branch_taken(exmem_branch_taken), .memwb_halt(memwb_halt),
    .pc_WEN(pc_WEN), .pc_redirect(pc_redirect),
    .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN), .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs are combinational per cycle, so one entry per cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [5:0] gw;
      logic [3:0] gf;
      e  = sb.pop_front();
      gw = {pc_WEN, pc_redirect, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN};
      gf = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
      checks++;
      if (gw !== e.w) begin
        errors++;
        $display("FAIL %s wen: got %b want %b", e.name, gw, e.w);
      end
      checks++;
      if (gf !== e.f) begin
        errors++;
        $display("FAIL %s flush: got %b want %b", e.name, gf, e.f);
      end
      checks++;
      if (halt !== e.h) begin
        errors++;
        $display("FAIL %s halt: got %b want %b", e.name, halt, e.h);
      end
      checks++;
      if (stall_cnt !== e.sc) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.sc);
      end
      checks++;
      if (flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.fc);
      end
    end
  end

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1;
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    idex_MemRead = 1'b0; idex_Jump = 1'b0;
    exmem_MemRead = 1'b0; exmem_MemWrite = 1'b0;
    exmem_branch_taken = 1'b0; memwb_halt = 1'b0;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input string n, input logic [5:0] w, input logic [3:0] f,
                     input logic h, input int sc, input int fc);
    exp_t e;
    e.name = n; e.w = w; e.f = f; e.h = h;
    e.sc = CW'(sc); e.fc = CW'(fc);
    sb.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2);
    idex_MemRead = 1'b1; idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    @(posedge CLK); #1;

    // reset state, release, first RUN cycle
    cyc("rst0", W_NONE, F_NONE, 0, 0, 0);
    cyc("rst1", W_NONE, F_NONE, 0, 0, 0);
    nRST = 1'b1;
    cyc("rel_reset_state", W_NONE, F_NONE, 0, 0, 0);
    cyc("first_run", W_ALL, F_NONE, 0, 0, 0);

    // load-use on rs, then r0 exemption, then match on rt, then no match
    set_lu(5'd5, 5'd5, 5'd0);
    cyc("lu_rs", W_LU, F_LU, 0, 0, 0);
    idle();
    cyc("lu_rs_after", W_ALL, F_NONE, 0, 1, 0);
    set_lu(5'd0, 5'd0, 5'd0);
    cyc("lu_r0", W_ALL, F_NONE, 0, 1, 0);
    set_lu(5'd7, 5'd3, 5'd7);
    cyc("lu_rt", W_LU, F_LU, 0, 1, 0);
    set_lu(5'd7, 5'd3, 5'd4);
    cyc("lu_nomatch", W_ALL, F_NONE, 0, 2, 0);
    idle();

    // data-cache wait for 3 cycles
    exmem_MemRead = 1'b1; dhit = 1'b0;
    cyc("memwait0", W_NONE, F_NONE, 0, 2, 0);
    cyc("memwait1", W_NONE, F_NONE, 0, 3, 0);
    cyc("memwait2", W_NONE, F_NONE, 0, 4, 0);
    dhit = 1'b1;
    cyc("memwait_done", W_ALL, F_NONE, 0, 5, 0);
    idle();
    cyc("memwait_after", W_ALL, F_NONE, 0, 5, 0);

    // branch beats simultaneous jump and load-use
    exmem_branch_taken = 1'b1; idex_Jump = 1'b1; set_lu(5'd5, 5'd5, 5'd0);
    cyc("br_over_all", W_RED, F_BR, 0, 5, 0);
    idle();
    cyc("br_after", W_ALL, F_NONE, 0, 5, 1);
    idex_Jump = 1'b1;
    cyc("jump", W_RED, F_J, 0, 5, 1);
    set_lu(5'd9, 5'd9, 5'd0);
    cyc("jump_over_lu", W_RED, F_J, 0, 5, 2);
    idle();
    cyc("jump_after", W_ALL, F_NONE, 0, 5, 3);

    // branch held during a store wait
    exmem_branch_taken = 1'b1; exmem_MemWrite = 1'b1; dhit = 1'b0;
    cyc("br_wait0", W_NONE, F_NONE, 0, 5, 3);
    cyc("br_wait1", W_NONE, F_NONE, 0, 6, 3);
    dhit = 1'b1;
    cyc("br_wait_done", W_RED, F_BR, 0, 7, 3);
    idle();
    cyc("br_wait_after", W_ALL, F_NONE, 0, 7, 4);

    // instruction miss
    ihit = 1'b0;
    cyc("imiss", W_NONE, F_NONE, 0, 7, 4);
    idle();
    cyc("imiss_after", W_ALL, F_NONE, 0, 8, 4);

    // halt wins over freeze and is absorbing
    memwb_halt = 1'b1; ihit = 1'b0;
    cyc("halt_seen", W_NONE, F_NONE, 0, 8, 4);
    idle();
    exmem_branch_taken = 1'b1;
    cyc("halted_br", W_NONE, F_NONE, 1, 8, 4);
    exmem_branch_taken = 1'b0; idex_Jump = 1'b1; set_lu(5'd5, 5'd5, 5'd0);
    cyc("halted_jump", W_NONE, F_NONE, 1, 8, 4);
    idle(); ihit = 1'b0;
    cyc("halted_imiss", W_NONE, F_NONE, 1, 8, 4);
    idle();

    // asynchronous reset mid-cycle clears halt and counters immediately
    nRST = 1'b0;
    cyc("async_rst", W_NONE, F_NONE, 0, 0, 0);
    nRST = 1'b1;
    cyc("rel2_reset_state", W_NONE, F_NONE, 0, 0, 0);
    cyc("run2", W_ALL, F_NONE, 0, 0, 0);

    // saturation of both counters
    ihit = 1'b0;
    for (int i = 0; i < 18; i++)
      cyc("stall_sat", W_NONE, F_NONE, 0, (i > 15) ? 15 : i, 0);
    idle();
    exmem_branch_taken = 1'b1;
    for (int i = 0; i < 18; i++)
      cyc("flush_sat", W_RED, F_BR, 0, 15, (i > 15) ? 15 : i);
    idle();
    cyc("sat_after", W_ALL, F_NONE, 0, 15, 15);

    // bounded drain of the scoreboard
    repeat (4) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control end of the four pipeline register interfaces: generates every WEN/flush for IF/ID, ID/EX, EX/MEM and MEM/WB, plus PC write enable and redirect select.
- Resolves cache wait stalls, load-use bubbles, branch/jump flushes and halt drain with a small FSM.
- Keeps saturating performance counters for stall and flush cycles.
- Sits beside the datapath in the pipelined CPU top; consumes hazard-relevant fields from the pipeline register outputs.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch complete this cycle
dhit  input  1  data access complete this cycle
ifid_rs  input  5  rs field of instruction in IF/ID
ifid_rt  input  5  rt field of instruction in IF/ID
idex_MemRead  input  1  M_MemRead_out of ID/EX
idex_rt  input  5  rt_out of ID/EX (load destination)
idex_Jump  input  1  M_Jump_out of ID/EX
exmem_MemRead  input  1  M_MemRead_out of EX/MEM
exmem_MemWrite  input  1  M_MemWrite_out of EX/MEM
exmem_branch_taken  input  1  M_Branch_out & branch condition, resolved in MEM
memwb_halt  input  1  halt_out of MEM/WB
pc_WEN  output  1  PC update enable
pc_redirect  output  1  PC takes branch/jump target this cycle
ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  output  1 each  register write enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  insert NOP on write
halt  output  1  CPU halted, registered
stall_cnt  output  CNT_W  cycles with any freeze or bubble, saturating
flush_cnt  output  CNT_W  cycles with a redirect flush, saturating

Behaviour:
- Clocking and reset: one clock, CLK. Reset is nRST, asynchronous, active-low.
- States: RESET, RUN, MEMWAIT, HALTED. nRST low forces RESET asynchronously, clears halt and both counters.
- RESET: all WEN=0, all flush=0, pc_WEN=0, pc_redirect=0. Always goes to RUN on the next edge.
- Every other output is 0 unless a rule below asserts it.
- Rules in RUN/MEMWAIT are evaluated in priority order; the first match wins.
- Priority 1, halt: memwb_halt=1.
  - All WEN=0, pc_WEN=0.
  - Next state HALTED; halt register set at that edge (halt=1 one cycle after memwb_halt is first seen).
- Priority 2, memory freeze: (exmem_MemRead|exmem_MemWrite)&!dhit, or !ihit.
  - All WEN=0, pc_WEN=0, no flush.
  - Next state MEMWAIT if the data term is active, else RUN.
  - A pending branch/load-use is held, not lost, because all registers are frozen; it is re-evaluated when the freeze clears.
- Priority 3, redirect: exmem_branch_taken=1.
  - pc_WEN=1, pc_redirect=1, all WEN=1.
  - ifid_flush=idex_flush=exmem_flush=1.
  - The redirect flush overrides any simultaneous jump or load-use.
- Priority 4, jump: idex_Jump=1.
  - pc_WEN=1, pc_redirect=1, all WEN=1, ifid_flush=1.
- Priority 5, load-use: idex_MemRead=1, idex_rt!=0, and idex_rt equals ifid_rs or ifid_rt.
  - pc_WEN=0, ifid_WEN=0, idex_WEN=1, idex_flush=1 (bubble), exmem_WEN=memwb_WEN=1.
- Otherwise: all WEN=1, pc_WEN=1, no flush.
- MEMWAIT: identical rule set to RUN. Returns to RUN on the first cycle the freeze term is 0.
- HALTED: all WEN=0, pc_WEN=0, halt=1. Absorbing until nRST.
- Counters:
  - stall_cnt increments on each RUN/MEMWAIT cycle where priority 2 or 5 fires.
  - flush_cnt increments on each cycle where priority 3 or 4 fires.
  - Both saturate at all-ones; neither counts in RESET or HALTED.
- Outputs other than halt and the counters are combinational from state and inputs. Zero-cycle latency.

Test Plan:
- nRST low mid-run with ihit=1 → all WEN=0, halt=0, counters 0; first cycle after release all WEN=0; second cycle all WEN=1, pc_WEN=1.
- idex_MemRead=1, idex_rt=5, ifid_rs=5, ihit=1 → one cycle with pc_WEN=0, ifid_WEN=0, idex_flush=1, stall_cnt 0→1; same stimulus with idex_rt=0 → no stall.
- exmem_MemRead=1, dhit=0 for 3 cycles, then 1 → 3 cycles with all WEN=0 in MEMWAIT, stall_cnt=3, back to RUN.
- exmem_branch_taken=1 with idex_Jump=1 and load-use true → pc_redirect=1, ifid/idex/exmem_flush=1, pc_WEN=1, flush_cnt+1, stall_cnt unchanged.
- Branch taken while dhit=0 for 2 cycles → no flush for 2 cycles; flush and redirect on the cycle dhit=1.
- memwb_halt=1 → next cycle halt=1, all WEN=0; holds with later ihit/branch activity until nRST. Force stall_cnt to all-ones → stays all-ones.
